ucie_ctl_sb_packet_parser: RTL and testbench

- Receive-side counterpart of the sideband packet builder.
- Accepts sideband packets as a serial stream of 32-bit phases: header phase 0, header phase 1, and optionally data phases 2 and 3.
- Checks opcode, destination ID, control parity and data parity, then presents the decoded message fields to the RDI-side message decoder with a one-cycle valid pulse.
- Sits between the sideband link receive path and the controller's RDI sideband decode logic.

---
 rtl/ucie_ctl_sb_packet_parser.sv | 115 +++++++++++
 tb/tb_ucie_ctl_sb_packet_parser.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_packet_parser.sv
// ucie_ctl_sb_packet_parser: receives sideband packets as 32-bit phases, checks
// opcode/dstid/parity and presents decoded message fields with a one-cycle valid.
module ucie_ctl_sb_packet_parser #(
    parameter logic [4:0] OPC_MSG_NODATA = 5'b10010,
    parameter logic [4:0] OPC_MSG_DATA   = 5'b11011,
    parameter logic [2:0] EXP_DSTID      = 3'b101,
    parameter int         GAP_TIMEOUT    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_phase_valid,
    input  logic [31:0] i_phase_data,
    output logic        o_msg_valid,
    output logic [4:0]  o_opcode,
    output logic [2:0]  o_srcid,
    output logic [7:0]  o_msg_code,
    output logic [7:0]  o_sub_code,
    output logic [15:0] o_info,
    output logic        o_has_data,
    output logic [63:0] o_data,
    output logic        o_parity_err,
    output logic        o_opcode_err,
    output logic        o_dst_err,
    output logic        o_frame_err,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_PH0, S_PH1, S_PH2, S_PH3} state_t;
    state_t      state, state_nxt;
    logic [31:0] ph0, ph1, ph2;
    logic [7:0]  gap_cnt;
    logic        gap_expire, done, has_data_w, cp_calc, dp_calc;
    logic        par_bad, opc_bad, dst_bad, good;
    logic [31:0] ph1_w;
    logic [63:0] data_w;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_PH0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (gap_expire) state_nxt = S_PH0;
        else if (i_phase_valid) begin
            case (state)
                S_PH0:   state_nxt = S_PH1;
                S_PH1:   state_nxt = (ph0[4:0] == OPC_MSG_DATA) ? S_PH2 : S_PH0;
                S_PH2:   state_nxt = S_PH3;
                default: state_nxt = S_PH0;
            endcase
        end
    end

    // The final phase is checked straight off the input so results register on its edge.
    always_comb begin
        o_busy     = state != S_PH0;
        gap_expire = o_busy && !i_phase_valid && gap_cnt == 8'(GAP_TIMEOUT - 1);
        done       = i_phase_valid && ((state == S_PH1 && ph0[4:0] != OPC_MSG_DATA) || state == S_PH3);
        has_data_w = state == S_PH3;
        ph1_w      = has_data_w ? ph1 : i_phase_data;
        data_w     = has_data_w ? {i_phase_data, ph2} : 64'h0;
        cp_calc    = ^{ph0, ph1_w[29:0]};
        dp_calc    = ^data_w;
        par_bad    = ph1_w[30] != cp_calc || ph1_w[31] != dp_calc;
        opc_bad    = ph0[4:0] != OPC_MSG_NODATA && ph0[4:0] != OPC_MSG_DATA;
        dst_bad    = ph1_w[26:24] != EXP_DSTID;
        good       = done && !par_bad && !opc_bad && !dst_bad;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ph0     <= '0;
            ph1     <= '0;
            ph2     <= '0;
            gap_cnt <= '0;
        end else begin
            if (i_phase_valid && state == S_PH0) ph0 <= i_phase_data;
            if (i_phase_valid && state == S_PH1) ph1 <= i_phase_data;
            if (i_phase_valid && state == S_PH2) ph2 <= i_phase_data;
            gap_cnt <= (!o_busy || i_phase_valid || gap_expire) ? 8'd0 : gap_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_msg_valid  <= 1'b0;
            o_parity_err <= 1'b0;
            o_opcode_err <= 1'b0;
            o_dst_err    <= 1'b0;
            o_frame_err  <= 1'b0;
            o_opcode     <= '0;
            o_srcid      <= '0;
            o_msg_code   <= '0;
            o_sub_code   <= '0;
            o_info       <= '0;
            o_has_data   <= 1'b0;
            o_data       <= '0;
        end else begin
            o_msg_valid  <= good;
            o_parity_err <= done && par_bad;
            o_opcode_err <= done && opc_bad;
            o_dst_err    <= done && dst_bad;
            o_frame_err  <= gap_expire;
            if (good) begin
                o_opcode   <= ph0[4:0];
                o_srcid    <= ph0[31:29];
                o_msg_code <= ph0[21:14];
                o_sub_code <= ph1_w[7:0];
                o_info     <= ph1_w[23:8];
                o_has_data <= has_data_w;
                o_data     <= data_w;
            end
        end
    end
endmodule

// File: tb/tb_ucie_ctl_sb_packet_parser.sv
// tb_ucie_ctl_sb_packet_parser: scoreboard bench; each packet pushes its predicted
// completion event and a negedge monitor pops and compares whenever a pulse appears.
module tb_ucie_ctl_sb_packet_parser;
    logic        i_clk, i_rst, i_phase_valid;
    logic [31:0] i_phase_data;
    logic        o_msg_valid, o_has_data, o_parity_err, o_opcode_err, o_dst_err, o_frame_err, o_busy;
    logic [4:0]  o_opcode;
    logic [2:0]  o_srcid;
    logic [7:0]  o_msg_code, o_sub_code;
    logic [15:0] o_info;
    logic [63:0] o_data;

    typedef struct packed {
        logic v, pe, oe, de, fe;
        logic [4:0]  opc;
        logic [2:0]  src;
        logic [7:0]  mc, sc;
        logic [15:0] info;
        logic        hd;
        logic [63:0] data;
    } ev_t;

    ev_t fields;
    ev_t sb[$];
    int  applied = 0;
    int  miscompares = 0;

    ucie_ctl_sb_packet_parser dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_phase_valid(i_phase_valid), .i_phase_data(i_phase_data),
        .o_msg_valid(o_msg_valid), .o_opcode(o_opcode), .o_srcid(o_srcid), .o_msg_code(o_msg_code),
        .o_sub_code(o_sub_code), .o_info(o_info), .o_has_data(o_has_data), .o_data(o_data),
        .o_parity_err(o_parity_err), .o_opcode_err(o_opcode_err), .o_dst_err(o_dst_err),
        .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic ev_t outs();
        return '{o_msg_valid, o_parity_err, o_opcode_err, o_dst_err, o_frame_err, o_opcode, o_srcid,
                 o_msg_code, o_sub_code, o_info, o_has_data, o_data};
    endfunction

    always @(negedge i_clk) begin
        if (i_rst && (o_msg_valid || o_parity_err || o_opcode_err || o_dst_err || o_frame_err)) begin
            ev_t e;
            applied++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse got=%h expected=none", outs());
            end else begin
                e = sb.pop_front();
                if (outs() !== e) begin
                    miscompares++;
                    $display("FAIL event got=%h expected=%h", outs(), e);
                end
            end
        end
    end

    task automatic predict(input logic [31:0] p0, p1, p2, p3, input bit data);
        ev_t e;
        logic [63:0] d;
        logic cp, dp;
        d = data ? {p3, p2} : 64'h0;
        cp = ^{p0, p1[29:0]};
        dp = ^d;
        e = fields;
        e.pe = (p1[30] != cp) || (p1[31] != dp);
        e.oe = p0[4:0] != 5'h12 && p0[4:0] != 5'h1B;
        e.de = p1[26:24] != 3'b101;
        if (!(e.pe || e.oe || e.de)) begin
            fields.opc  = p0[4:0];
            fields.src  = p0[31:29];
            fields.mc   = p0[21:14];
            fields.sc   = p1[7:0];
            fields.info = p1[23:8];
            fields.hd   = data;
            fields.data = d;
            e = fields;
            e.v = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic send_phase(input logic [31:0] d);
        i_phase_valid = 1'b1;
        i_phase_data  = d;
        @(posedge i_clk); #1;
        i_phase_valid = 1'b0;
        i_phase_data  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic send_pkt(input logic [31:0] p0, p1, p2, p3);
        bit data;
        data = p0[4:0] == 5'h1B;
        predict(p0, p1, p2, p3, data);
        send_phase(p0);
        send_phase(p1);
        if (data) begin
            send_phase(p2);
            send_phase(p3);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_phase_valid = 1'b0;
        i_phase_data = '0;
        fields = '0;
        idle(2);
        applied++;
        if ({outs(), o_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h expected=0", {outs(), o_busy});
        end
        i_rst = 1'b1;
        idle(1);
    endtask

    task automatic test_nodata();
        send_pkt(32'h2000_4012, 32'h0500_0000, 0, 0);
        applied++;
        if ({o_msg_valid, o_opcode, o_srcid, o_msg_code, o_sub_code, o_info, o_has_data, o_data} !==
            {1'b1, 5'h12, 3'd1, 8'h01, 8'h00, 16'h0, 1'b0, 64'h0}) begin
            miscompares++;
            $display("FAIL nodata_fields got=%h valid=%b", {o_opcode, o_srcid, o_msg_code}, o_msg_valid);
        end
        idle(2);
    endtask

    task automatic test_data();
        send_pkt(32'h2000_401B, 32'h8500_0000, 32'h0000_0001, 32'h0000_0000);
        applied++;
        if ({o_msg_valid, o_has_data, o_data} !== {1'b1, 1'b1, 64'h1}) begin
            miscompares++;
            $display("FAIL data_fields got=%b/%b/%h expected=1/1/1", o_msg_valid, o_has_data, o_data);
        end
        idle(2);
    endtask

    task automatic test_parity();
        send_pkt(32'h2000_4012, 32'h4500_0000, 0, 0);
        applied++;
        if ({o_parity_err, o_msg_valid, o_data} !== {1'b1, 1'b0, 64'h1}) begin
            miscompares++;
            $display("FAIL cp_error got=%b/%b/%h expected=1/0/1", o_parity_err, o_msg_valid, o_data);
        end
        idle(2);
        send_pkt(32'h2000_401B, 32'h0500_0000, 32'h0000_0001, 32'h0000_0000);
        idle(2);
    endtask

    task automatic test_dst_opcode();
        send_pkt(32'h2000_4012, 32'h4400_0000, 0, 0);
        applied++;
        if ({o_dst_err, o_parity_err, o_opcode_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL dst_error got=%b expected=100", {o_dst_err, o_parity_err, o_opcode_err});
        end
        idle(1);
        send_pkt(32'h2000_4001, 32'h4500_0000, 0, 0);
        applied++;
        if ({o_opcode_err, o_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL opcode_error got=%b expected=10", {o_opcode_err, o_busy});
        end
        idle(1);
        send_pkt(32'h2000_4001, 32'h0400_0000, 0, 0);
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] p0, p1, p2, p3;
            p0 = $urandom;
            p1 = $urandom;
            p2 = $urandom;
            p3 = $urandom;
            p0[4:0] = (i % 3 == 0) ? 5'h12 : (i % 3 == 1) ? 5'h1B : p0[4:0];
            if (i % 4 != 3) p1[26:24] = 3'b101;
            if (i % 2 == 0) begin
                p1[30] = ^{p0, p1[29:0]};
                p1[31] = (p0[4:0] == 5'h1B) ? ^{p2, p3} : 1'b0;
            end
            send_pkt(p0, p1, p2, p3);
            idle($urandom_range(0, 3));
        end
        idle(2);
    endtask

    task automatic test_gap_timeout();
        ev_t e;
        e = fields;
        e.fe = 1'b1;
        sb.push_back(e);
        send_phase(32'h2000_4012);
        idle(7);
        applied++;
        if ({o_frame_err, o_busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL gap_early got=%b expected=01", {o_frame_err, o_busy});
        end
        idle(1);
        applied++;
        if ({o_frame_err, o_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL gap_expire got=%b expected=10", {o_frame_err, o_busy});
        end
        send_pkt(32'h6000_8012, 32'h0512_3456, 0, 0);
        idle(1);
        predict(32'h2000_4012, 32'h05AB_CD00, 0, 0, 1'b0);
        send_phase(32'h2000_4012);
        idle(7);
        send_phase(32'h05AB_CD00);
        applied++;
        if ({o_msg_valid, o_frame_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL gap_last_cycle got=%b expected=10", {o_msg_valid, o_frame_err});
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        send_phase(32'h2000_401B);
        send_phase(32'h8500_0000);
        send_phase(32'h0000_0001);
        i_rst = 1'b0;
        fields = '0;
        idle(1);
        applied++;
        if ({outs(), o_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got=%h expected=0", {outs(), o_busy});
        end
        i_rst = 1'b1;
        idle(3);
        applied++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_busy got=%b expected=0", o_busy);
        end
    endtask

    task automatic test_back_to_back();
        predict(32'h2000_4012, 32'h0500_0000, 0, 0, 1'b0);
        predict(32'hA03F_C012, 32'h0511_2233, 0, 0, 1'b0);
        send_phase(32'h2000_4012);
        send_phase(32'h0500_0000);
        applied++;
        if (o_msg_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first got=%b expected=1", o_msg_valid);
        end
        send_phase(32'hA03F_C012);
        applied++;
        if (o_msg_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap got=%b expected=0", o_msg_valid);
        end
        send_phase(32'h0511_2233);
        applied++;
        if (o_msg_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second got=%b expected=1", o_msg_valid);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_nodata();
        test_data();
        test_parity();
        test_dst_opcode();
        test_random();
        test_gap_timeout();
        test_reset_mid();
        test_back_to_back();
        applied++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events got=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
